// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : control_sequencer
//  Purpose  : Multi-cycle microsequencer for the shared datapath bus. Fetches
//             the 16-bit instruction in IR, decodes it and, every cycle,
//             drives the bus source code, one-hot destination write enables
//             and the memory / ALU strobes.
//  Ports    : clk, rst_n (sync, active-low), start, ir[15:0], z_flag
//             -> read_en[RE_W-1:0], wr_en[N_DST-1:0], pc_inc, im_rd, dm_rd,
//                dm_wr, alu_en, alu_op[2:0], halt, err
//  Revision : 1.0  initial release
// ============================================================================
module control_sequencer #(
    parameter int RE_W    = 5,
    parameter int N_DST   = 18,
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      ir,
    input  logic             z_flag,
    output logic [RE_W-1:0]  read_en,
    output logic [N_DST-1:0] wr_en,
    output logic             pc_inc,
    output logic             im_rd,
    output logic             dm_rd,
    output logic             dm_wr,
    output logic             alu_en,
    output logic [2:0]       alu_op,
    output logic             halt,
    output logic             err
);

    // Bus source codes; a register's source code is also its wr_en bit.
    localparam logic [RE_W-1:0] c_src_none = RE_W'(0);
    localparam logic [RE_W-1:0] c_src_dm   = RE_W'(1);
    localparam logic [RE_W-1:0] c_src_im   = RE_W'(2);
    localparam logic [RE_W-1:0] c_src_pc   = RE_W'(3);
    localparam logic [RE_W-1:0] c_src_ir   = RE_W'(4);
    localparam logic [RE_W-1:0] c_src_ar   = RE_W'(5);
    localparam logic [RE_W-1:0] c_src_ac   = RE_W'(6);
    localparam logic [RE_W-1:0] c_src_r    = RE_W'(13);
    localparam logic [RE_W-1:0] c_src_dr   = RE_W'(17);

    // Wait counter loads MEM_LAT-1 and counts down to 0, so the first wait
    // cycle is the one where the counter still holds its load value.
    localparam logic [2:0] c_wait_init = 3'(MEM_LAT - 1);

    typedef enum logic [4:0] {
        S_IDLE, S_FETCH1, S_FWAIT, S_FETCH3, S_DECODE,
        S_LD1, S_DWAIT, S_LD3,
        S_ST1, S_ST2, S_ST3,
        S_MVAC, S_MVR, S_ADD, S_SUB, S_JMPZ,
        S_HALTED
    } state_t;

    state_t          r_state;
    logic [2:0]      r_wait;
    logic            r_err;

    logic [RE_W-1:0] w_rc;
    logic            w_rc_ok;
    logic            w_unused;

    assign w_rc     = RE_W'(ir[4:0]);
    // Register code must name a real register other than AC (code 0 is "none").
    assign w_rc_ok  = (w_rc != c_src_none) && (w_rc != c_src_ac) && (int'(w_rc) < N_DST);
    assign w_unused = &{1'b0, ir[7:5]};

    function automatic logic [N_DST-1:0] dst(input logic [RE_W-1:0] code);
        return N_DST'(1) << code;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wait  <= 3'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:   if (start) r_state <= S_FETCH1;
                S_FETCH1: begin
                    r_wait  <= c_wait_init;
                    r_state <= S_FWAIT;
                end
                S_FWAIT:  if (r_wait == 3'd0) r_state <= S_FETCH3;
                          else                r_wait  <= r_wait - 3'd1;
                S_FETCH3: r_state <= S_DECODE;
                S_DECODE: begin
                    case (ir[15:8])
                        8'h00:   r_state <= S_FETCH1;
                        8'h01:   r_state <= S_LD1;
                        8'h02:   r_state <= S_ST1;
                        8'h03:   r_state <= S_MVAC;
                        8'h04:   r_state <= S_MVR;
                        8'h05:   r_state <= S_ADD;
                        8'h06:   r_state <= S_SUB;
                        8'h07:   r_state <= S_JMPZ;
                        8'hFF:   r_state <= S_HALTED;
                        default: begin
                            r_err   <= 1'b1;
                            r_state <= S_HALTED;
                        end
                    endcase
                end
                S_LD1: begin
                    r_wait  <= c_wait_init;
                    r_state <= S_DWAIT;
                end
                S_DWAIT:  if (r_wait == 3'd0) r_state <= S_LD3;
                          else                r_wait  <= r_wait - 3'd1;
                S_LD3:    r_state <= S_FETCH1;
                S_ST1:    r_state <= S_ST2;
                S_ST2:    r_state <= S_ST3;
                S_ST3:    r_state <= S_FETCH1;
                S_MVAC, S_MVR: begin
                    // A bad register code is flagged but execution carries on.
                    if (!w_rc_ok) r_err <= 1'b1;
                    r_state <= S_FETCH1;
                end
                S_ADD, S_SUB, S_JMPZ: r_state <= S_FETCH1;
                S_HALTED: r_state <= S_HALTED;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        read_en = c_src_none;
        wr_en   = '0;
        pc_inc  = 1'b0;
        im_rd   = 1'b0;
        dm_rd   = 1'b0;
        dm_wr   = 1'b0;
        alu_en  = 1'b0;
        alu_op  = 3'b000;
        halt    = 1'b0;
        case (r_state)
            S_FETCH1: begin read_en = c_src_pc; wr_en = dst(c_src_ar); end
            S_FWAIT:  im_rd = (r_wait == c_wait_init);
            S_FETCH3: begin read_en = c_src_im; wr_en = dst(c_src_ir); pc_inc = 1'b1; end
            S_LD1, S_ST1: begin read_en = c_src_ir; wr_en = dst(c_src_ar); end
            S_DWAIT:  dm_rd = (r_wait == c_wait_init);
            S_LD3:    begin read_en = c_src_dm; wr_en = dst(c_src_ac); end
            S_ST2:    begin read_en = c_src_ac; wr_en = dst(c_src_dr); end
            S_ST3:    dm_wr = 1'b1;
            S_MVAC:   if (w_rc_ok) begin read_en = c_src_ac; wr_en = dst(w_rc); end
            S_MVR:    if (w_rc_ok) begin read_en = w_rc; wr_en = dst(c_src_ac); end
            S_ADD:    begin read_en = c_src_r; alu_en = 1'b1; alu_op = 3'b000; end
            S_SUB:    begin read_en = c_src_r; alu_en = 1'b1; alu_op = 3'b001; end
            S_JMPZ:   if (z_flag) begin read_en = c_src_ir; wr_en = dst(c_src_pc); end
            S_HALTED: halt = 1'b1;
            default:  ;
        endcase
    end

    assign err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_sequencer
//  Purpose  : Self-checking bench for control_sequencer. Two instances
//             (MEM_LAT=1 and MEM_LAT=3) are exercised in turn with directed
//             and randomized instruction streams; an instruction-level model
//             predicts every output cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_control_sequencer;

    typedef struct packed {
        logic [4:0]  re;
        logic [17:0] we;
        logic        pc;
        logic        im;
        logic        dmr;
        logic        dmw;
        logic        alu;
        logic [2:0]  op;
        logic        hlt;
        logic        er;
    } vec_t;

    logic        clk = 1'b0;
    logic [1:0]  rst_n = 2'b00;
    logic        start = 1'b0;
    logic [15:0] ir = 16'h0000;
    logic        z_flag = 1'b0;

    logic [4:0]  re_o  [2];
    logic [17:0] we_o  [2];
    logic        pc_o  [2];
    logic        im_o  [2];
    logic        dmr_o [2];
    logic        dmw_o [2];
    logic        alu_o [2];
    logic [2:0]  op_o  [2];
    logic        hlt_o [2];
    logic        err_o [2];

    int   checks = 0;
    int   errors = 0;
    int   sel = 0;
    int   lat = 1;
    logic nrst = 1'b0;
    logic [15:0] next_ir = 16'h0000;
    logic m_err = 1'b0;
    bit   pin_err = 1'b0;

    vec_t exp_q[$];
    bit   chk_q[$];
    int   sel_q[$];
    vec_t ce, ca;
    bit   cc;
    int   cs;

    logic [4:0]  a_re;
    logic [17:0] a_we;
    logic        a_im, a_alu, a_hlt, a_err;
    logic [2:0]  a_op;

    always #5 clk = ~clk;

    control_sequencer #(.RE_W(5), .N_DST(18), .MEM_LAT(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n[0]), .start(start), .ir(ir), .z_flag(z_flag),
        .read_en(re_o[0]), .wr_en(we_o[0]), .pc_inc(pc_o[0]), .im_rd(im_o[0]),
        .dm_rd(dmr_o[0]), .dm_wr(dmw_o[0]), .alu_en(alu_o[0]), .alu_op(op_o[0]),
        .halt(hlt_o[0]), .err(err_o[0])
    );

    control_sequencer #(.RE_W(5), .N_DST(18), .MEM_LAT(3)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n[1]), .start(start), .ir(ir), .z_flag(z_flag),
        .read_en(re_o[1]), .wr_en(we_o[1]), .pc_inc(pc_o[1]), .im_rd(im_o[1]),
        .dm_rd(dmr_o[1]), .dm_wr(dmw_o[1]), .alu_en(alu_o[1]), .alu_op(op_o[1]),
        .halt(hlt_o[1]), .err(err_o[1])
    );

    assign a_re  = re_o[sel];
    assign a_we  = we_o[sel];
    assign a_im  = im_o[sel];
    assign a_alu = alu_o[sel];
    assign a_op  = op_o[sel];
    assign a_hlt = hlt_o[sel];
    assign a_err = err_o[sel];

    function automatic vec_t actual(input int s);
        vec_t v;
        v.re = re_o[s];  v.we = we_o[s];   v.pc = pc_o[s];   v.im = im_o[s];
        v.dmr = dmr_o[s]; v.dmw = dmw_o[s]; v.alu = alu_o[s]; v.op = op_o[s];
        v.hlt = hlt_o[s]; v.er = err_o[s];
        return v;
    endfunction

    // Single compare process: every driven cycle has one expected vector.
    always @(negedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            cc = chk_q.pop_front();
            cs = sel_q.pop_front();
            ca = actual(cs);
            if (cc) begin
                checks++;
                if (ca !== ce) begin
                    errors++;
                    $display("FAIL outputs inst=%0d t=%0t: got re=%0d we=%h pc=%b im=%b dmr=%b dmw=%b alu=%b op=%0d halt=%b err=%b ; want re=%0d we=%h pc=%b im=%b dmr=%b dmw=%b alu=%b op=%0d halt=%b err=%b",
                             cs, $time, ca.re, ca.we, ca.pc, ca.im, ca.dmr, ca.dmw, ca.alu, ca.op, ca.hlt, ca.er,
                             ce.re, ce.we, ce.pc, ce.im, ce.dmr, ce.dmw, ce.alu, ce.op, ce.hlt, ce.er);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t zv();
        vec_t v;
        v = '0;
        v.er = m_err;
        return v;
    endfunction

    function automatic logic [17:0] bitv(input int i);
        logic [17:0] b;
        b = '0;
        b[i] = 1'b1;
        return b;
    endfunction

    task automatic pin(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic cyc(input vec_t e, input logic st, input logic z, input bit chk);
        @(negedge clk);
        start = st;
        z_flag = z;
        ir = next_ir;
        rst_n[sel] = nrst;
        rst_n[1-sel] = 1'b0;
        exp_q.push_back(e);
        chk_q.push_back(chk);
        sel_q.push_back(sel);
    endtask

    task automatic c(input vec_t e);
        cyc(e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    endtask

    // Instruction-level model: returns 1 if the instruction halts.
    task automatic run_instr(input logic [15:0] iv, output bit halted);
        vec_t e;
        logic [7:0] opc;
        logic [4:0] rc;
        bit ok;
        logic zz;
        opc = iv[15:8];
        rc  = iv[4:0];
        ok  = (rc != 5'd0) && (rc != 5'd6) && (rc <= 5'd17);
        halted = 1'b0;
        next_ir = iv;

        e = zv(); e.re = 5'd3; e.we = bitv(5); c(e);
        if (pin_err) begin
            #1; pin("err_sticky_after_bad_mv", 32'(a_err), 32'd1);
            pin_err = 1'b0;
        end
        for (int i = 0; i < lat; i++) begin e = zv(); e.im = (i == 0); c(e); end
        e = zv(); e.re = 5'd2; e.we = bitv(4); e.pc = 1'b1; c(e);
        c(zv());

        case (opc)
            8'h00: ;
            8'h01: begin
                e = zv(); e.re = 5'd4; e.we = bitv(5); c(e);
                if (iv == 16'h0110) begin #1; pin("ldac_ex1", 32'({a_re, a_we}), 32'({5'd4, 18'h00020})); end
                for (int i = 0; i < lat; i++) begin e = zv(); e.dmr = (i == 0); c(e); end
                e = zv(); e.re = 5'd1; e.we = bitv(6); c(e);
                if (iv == 16'h0110) begin #1; pin("ldac_ex3", 32'({a_re, a_we}), 32'({5'd1, 18'h00040})); end
            end
            8'h02: begin
                e = zv(); e.re = 5'd4; e.we = bitv(5); c(e);
                e = zv(); e.re = 5'd6; e.we = bitv(17); c(e);
                e = zv(); e.dmw = 1'b1; c(e);
            end
            8'h03: begin
                e = zv(); if (ok) begin e.re = 5'd6; e.we = bitv(int'(rc)); end c(e);
                if (iv == 16'h0307) begin #1; pin("mvac_lit", 32'({a_re, a_we}), 32'({5'd6, 18'h00080})); end
                if (iv == 16'h0315) begin #1; pin("mvac_bad_nowrite", 32'({a_re, a_we}), 32'd0); end
                if (!ok) begin m_err = 1'b1; pin_err = 1'b1; end
            end
            8'h04: begin
                e = zv(); if (ok) begin e.re = rc; e.we = bitv(6); end c(e);
                if (iv == 16'h040F) begin #1; pin("mvr_lit", 32'({a_re, a_we}), 32'({5'd15, 18'h00040})); end
                if (!ok) begin m_err = 1'b1; pin_err = 1'b1; end
            end
            8'h05, 8'h06: begin
                e = zv(); e.re = 5'd13; e.alu = 1'b1; e.op = (opc == 8'h06) ? 3'd1 : 3'd0; c(e);
                if (iv == 16'h0600) begin #1; pin("sub_lit", 32'({a_re, a_alu, a_op}), 32'({5'd13, 1'b1, 3'd1})); end
            end
            8'h07: begin
                zz = 1'($urandom_range(0, 1));
                e = zv(); if (zz) begin e.re = 5'd4; e.we = bitv(3); end
                cyc(e, 1'($urandom_range(0, 1)), zz, 1'b1);
                if (iv == 16'h0720 && zz) begin #1; pin("jmpz_taken", 32'({a_re, a_we}), 32'({5'd4, 18'h00008})); end
            end
            8'hFF: halted = 1'b1;
            default: begin m_err = 1'b1; halted = 1'b1; end
        endcase
    endtask

    task automatic halted_cycles(input int n);
        vec_t e;
        for (int i = 0; i < n; i++) begin
            e = zv(); e.hlt = 1'b1;
            cyc(e, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    task automatic reset_to_idle_and_start();
        nrst = 1'b1;
        m_err = 1'b0;
        pin_err = 1'b0;
        cyc(zv(), 1'b0, 1'b0, 1'b1);
        cyc(zv(), 1'b1, 1'($urandom_range(0, 1)), 1'b1);
    endtask

    task automatic run_all(input int s);
        vec_t e;
        bit h;
        logic [15:0] iv;
        sel = s;
        lat = (s == 0) ? 1 : 3;
        m_err = 1'b0;
        pin_err = 1'b0;
        next_ir = 16'h0000;

        // Reset for two cycles; the first cycle's state is not yet defined.
        nrst = 1'b0;
        cyc(zv(), 1'b0, 1'b0, 1'b0);
        cyc(zv(), 1'b0, 1'b0, 1'b1);
        nrst = 1'b1;
        repeat (5) cyc(zv(), 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        #1; pin("idle_read_en", 32'(a_re), 32'd0);
        cyc(zv(), 1'b1, 1'b0, 1'b1);

        run_instr(16'h0000, h);
        run_instr(16'h0110, h);
        run_instr(16'h02AB, h);
        run_instr(16'h0307, h);
        run_instr(16'h040F, h);
        run_instr(16'h0600, h);
        run_instr(16'h0512, h);
        repeat (4) run_instr(16'h0720, h);
        run_instr(16'h0315, h);
        run_instr(16'h0400, h);
        run_instr(16'h0306, h);
        for (int k = 0; k < 40; k++) begin
            iv = {8'($urandom_range(0, 7)), 8'($urandom_range(0, 255))};
            run_instr(iv, h);
        end

        // Reset asserted during the first fetch wait cycle.
        next_ir = 16'h0000;
        e = zv(); e.re = 5'd3; e.we = bitv(5); c(e);
        nrst = 1'b0;
        e = zv(); e.im = 1'b1; c(e);
        nrst = 1'b1;
        m_err = 1'b0;
        pin_err = 1'b0;
        cyc(zv(), 1'b0, 1'b0, 1'b1);
        #1; pin("rst_midwait_err", 32'(a_err), 32'd0);
        pin("rst_midwait_im", 32'(a_im), 32'd0);
        cyc(zv(), 1'b1, 1'b0, 1'b1);

        // Illegal opcode: error and halt, start ignored afterwards.
        run_instr(16'h9A00, h);
        halted_cycles(10);
        #1; pin("illegal_halt", 32'({a_hlt, a_err}), 32'b11);

        nrst = 1'b0;
        e = zv(); e.hlt = 1'b1; c(e);
        reset_to_idle_and_start();
        run_instr(16'h0512, h);
        run_instr(16'hFF00, h);
        halted_cycles(3);
        #1; pin("halt_opcode", 32'({a_hlt, a_err}), 32'b10);
    endtask

    initial begin
        run_all(0);
        run_all(1);
        repeat (2) @(negedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle microsequencer sitting directly upstream of the shared datapath bus.
- Fetches and decodes the 16-bit instruction held in IR.
- Each cycle, drives the bus source select (read_en), the one-hot register write enables, and the memory/ALU strobes.
- Only the sequencer issues bus source selects; the bus multiplexer consumes read_en as-is.

Parameters:
- RE_W, 5, width of read_en (bus source code).
- N_DST, 18, width of wr_en; bit i writes the register whose bus source code is i; bit 0 unused.
- MEM_LAT, 1, wait cycles (1..7) between a memory read strobe and valid memory data on the bus.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  in  1  leave IDLE and begin fetching; sampled only in IDLE.
- ir  in  16  current IR contents; opcode = ir[15:8], operand = ir[7:0].
- z_flag  in  1  ALU zero flag.
- read_en  out  RE_W  bus source code.
- wr_en  out  N_DST  one-hot destination write enables.
- pc_inc  out  1  PC += 1 this cycle.
- im_rd  out  1  instruction-memory read strobe, address = AR.
- dm_rd  out  1  data-memory read strobe, address = AR.
- dm_wr  out  1  data-memory write strobe, data = DR.
- alu_en  out  1  AC <= AC op bus.
- alu_op  out  3  000 ADD, 001 SUB, others reserved.
- halt  out  1  sequencer stopped.
- err  out  1  illegal opcode or register code seen; sticky until reset.

Behaviour:
- Bus source codes:
  - 0 none
  - 1 DM
  - 2 IM
  - 3 PC
  - 4 IR
  - 5 AR
  - 6 AC
  - 7 X
  - 8 Y
  - 9 Z
  - 10 STXY
  - 11 STYZ
  - 12 STXZ
  - 13 R
  - 14 R1
  - 15 R2
  - 16 R3
  - 17 DR
  - 18..31 illegal.
- Reset:
  - While rst_n=0 at a posedge: state <= IDLE, wait counter <= 0, err <= 0.
  - All outputs decode to 0 in IDLE.
  - Reset overrides every state, including mid-wait; no strobe appears in the cycle after reset.
- Outputs are a combinational decode of the registered state, plus ir[4:0] for the MV instructions. Only signals listed for a state are nonzero in it.
- IDLE: start=1 -> FETCH1, else stay.
- Fetch sequence:
  - FETCH1: read_en=3, wr_en[5]=1 (AR <= PC).
  - FWAIT: im_rd=1 in the first cycle only; stays MEM_LAT cycles using a down-counter.
  - FETCH3: read_en=2, wr_en[4]=1, pc_inc=1.
  - DECODE: no outputs; branches on opcode.
- Opcodes:
  - 0x00 NOP: -> FETCH1.
  - 0x01 LDAC:
    - EX1: read_en=4, wr_en[5].
    - DWAIT: dm_rd first cycle, MEM_LAT cycles.
    - EX3: read_en=1, wr_en[6].
    - -> FETCH1.
  - 0x02 STAC:
    - EX1: read_en=4, wr_en[5].
    - EX2: read_en=6, wr_en[17].
    - EX3: dm_wr=1.
    - -> FETCH1.
  - 0x03 MVAC: one EX cycle, read_en=6, wr_en[ir[4:0]]=1.
  - 0x04 MVR: one EX cycle, read_en=ir[4:0], wr_en[6]=1.
  - 0x05 ADD / 0x06 SUB: one EX cycle, read_en=13, alu_en=1, alu_op=000/001.
  - 0x07 JMPZ: one EX cycle; if z_flag=1 in that cycle, read_en=4 and wr_en[3]=1; otherwise no outputs.
  - 0xFF HALT: -> HALTED.
  - Any other opcode: err <= 1, -> HALTED.
- MVAC/MVR with ir[4:0] equal to 0, 6, or >17:
  - No read or write in the EX cycle.
  - err <= 1.
  - Continue to FETCH1; do not halt.
- HALTED: halt=1, all other outputs 0. Stays until reset; start is ignored.
- Invariants:
  - At most one wr_en bit is set per cycle.
  - read_en is 0 in every cycle with no bus transfer.
  - Strobes are single-cycle.
- Instruction length at MEM_LAT=1:
  - Fetch plus decode: 4 cycles.
  - LDAC: +3; STAC: +3; all other executable instructions: +1.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles, then release with start=0 for 5 cycles -> all outputs 0, state IDLE.
- Fetch: pulse start, ir=0x0000 -> read_en sequence 3, 0, 2, 0 (FETCH1, FWAIT, FETCH3, DECODE); wr_en[5] in cycle 1; im_rd in cycle 2; wr_en[4] and pc_inc in cycle 3; FETCH1 again in cycle 5.
- LDAC: ir=0x0110, MEM_LAT=1 -> after DECODE, read_en=4 with wr_en[5]; then dm_rd; then read_en=1 with wr_en[6]; then FETCH1. Repeat with MEM_LAT=3 -> exactly 3 wait cycles, dm_rd high only in the first.
- MV and ALU: ir=0x0307 -> read_en=6, wr_en[7]. ir=0x040F -> read_en=15, wr_en[6]. ir=0x0600 -> read_en=13, alu_en=1, alu_op=001.
- JMPZ: ir=0x0720 with z_flag=1 -> read_en=4, wr_en[3]. Same ir with z_flag=0 -> EX cycle all outputs 0.
- Error/halt/reset: ir=0x0315 -> err=1, no write, fetch continues. ir=0x9A00 -> err=1, halt=1 held across 10 cycles including start=1. Drive rst_n=0 in the FWAIT cycle of a fetch -> next cycle IDLE, err=0, im_rd=0.
